// File: rtl/manchester_frame_decoder_pkg.sv
// -----------------------------------------------------------------------------
// man_pkg
// Shared types and helpers for the Manchester frame decoder.
//   state_t     : FSM state encoding, also exported on the o_state debug port
//   MODE_IEEE   : mode input value where a rising mid-bit edge encodes a 1
//   MODE_THOMAS : mode input value where a falling mid-bit edge encodes a 1
//   lock_of()   : first timing-counter value at which a mid-bit edge is taken
//   win_of()    : last timing-counter value at which a mid-bit edge is taken
// -----------------------------------------------------------------------------
package man_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'b00,
      DATA = 2'b01,
      DONE = 2'b11
   } state_t;

   localparam logic MODE_IEEE   = 1'b0;
   localparam logic MODE_THOMAS = 1'b1;

   // Edges earlier than 3/4 of a bit period are bit-boundary transitions.
   function automatic int lock_of(input int spb);
      return (3 * spb) / 4;
   endfunction

   // Mid-bit edges later than 5/4 of a bit period are treated as lost.
   function automatic int win_of(input int spb);
      return (5 * spb) / 4;
   endfunction

endpackage

// File: rtl/manchester_frame_decoder_edge_sync.sv
// -----------------------------------------------------------------------------
// man_edge_sync
// Brings an asynchronous serial line into the clk domain through two flops,
// then compares against a third flop to produce single-cycle edge strobes.
//   clk     : receiver clock
//   rst     : asynchronous, active-low reset (all stages cleared to 0)
//   i_data  : raw asynchronous serial line
//   o_edge  : one-cycle strobe on any transition of the synchronised line
//   o_rise  : one-cycle strobe on a rising transition of the synchronised line
// -----------------------------------------------------------------------------
module man_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_data,
   output logic o_edge,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   // Synchroniser pair plus the history flop used for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_data;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_edge = r_sync2 ^ r_sync3;
   assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/manchester_frame_decoder.sv
// -----------------------------------------------------------------------------
// manchester_frame_decoder
// Oversampled Manchester receiver: recovers bits from mid-bit edges using a
// lockout/window timing counter, hunts for a sync word, assembles FRAME_W data
// bits LSB-first and presents each frame on a valid/ready interface.
//   clk        : receiver clock (SPB clocks per Manchester bit)
//   rst        : asynchronous, active-low reset
//   data       : raw asynchronous Manchester line
//   mode       : 0 = IEEE 802.3 (rising = 1), 1 = G.E. Thomas (falling = 1)
//   o_data     : received frame, bit 0 = first data bit; stable while o_valid
//   o_valid    : frame available, held until accepted
//   i_ready    : consumer accept
//   o_err      : one-cycle pulse on a mid-bit timeout inside a frame
//   o_overrun  : one-cycle pulse when a finished frame is dropped
//   o_state    : current FSM state
//   o_bitcnt   : data bits received in the current frame
// -----------------------------------------------------------------------------
module manchester_frame_decoder
   import man_pkg::*;
#(
   parameter int                  SPB          = 8,
   parameter int                  FRAME_W      = 16,
   parameter int                  SYNC_LEN     = 4,
   parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           data,
   input  logic                           mode,
   output logic [FRAME_W-1:0]             o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic                           o_err,
   output logic                           o_overrun,
   output logic [1:0]                     o_state,
   output logic [$clog2(FRAME_W+1)-1:0]   o_bitcnt
);

   localparam int LOCK = lock_of(SPB);
   localparam int WIN  = win_of(SPB);
   localparam int TCW  = $clog2(WIN + 2);
   localparam int BCW  = $clog2(FRAME_W + 1);

   localparam logic [TCW-1:0]     LOCK_C = TCW'(LOCK);
   localparam logic [TCW-1:0]     WIN_C  = TCW'(WIN);
   localparam logic [TCW-1:0]     SAT_C  = TCW'(WIN + 1);
   localparam logic [TCW-1:0]     TONE_C = TCW'(1);
   localparam logic [BCW-1:0]     LAST_C = BCW'(FRAME_W - 1);
   localparam logic [BCW-1:0]     BONE_C = BCW'(1);
   localparam logic [FRAME_W-1:0] FONE_C = FRAME_W'(1);

   logic                 w_edge;
   logic                 w_rise;
   logic                 w_mode;
   logic                 w_bit;
   logic                 w_in_win;
   logic                 w_accept;
   logic                 w_timeout;
   logic                 w_match;
   logic                 w_last;
   logic [FRAME_W-1:0]   w_mask;
   state_t               w_next;

   state_t               r_state;
   logic [TCW-1:0]       r_tcnt;
   logic                 r_first;
   logic [SYNC_LEN-1:0]  r_shift;
   logic                 r_mode;
   logic [FRAME_W-1:0]   r_asm;
   logic [BCW-1:0]       r_bitcnt;
   logic [FRAME_W-1:0]   r_data;
   logic                 r_valid;
   logic                 r_err;
   logic                 r_overrun;

   man_edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .i_data (data),
      .o_edge (w_edge),
      .o_rise (w_rise)
   );

   // The live mode input only steers decoding while hunting; a frame in
   // progress keeps the polarity captured when its sync word matched.
   assign w_mode    = (r_state == HUNT) ? mode : r_mode;
   assign w_bit     = w_rise ^ (w_mode == MODE_THOMAS);
   assign w_in_win  = (r_tcnt >= LOCK_C) && (r_tcnt <= WIN_C);
   // r_first lets the very first edge after reset/timeout through unconditionally.
   assign w_accept  = w_edge && (r_first || w_in_win);
   // Fires once, on the clock at which tcnt would step to WIN+1.
   assign w_timeout = !w_accept && (r_tcnt == WIN_C);
   assign w_match   = (r_shift == SYNC_PATTERN);
   assign w_last    = (r_bitcnt == LAST_C);
   assign w_mask    = FONE_C << r_bitcnt;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         HUNT: begin
            if (w_timeout) begin
               w_next = HUNT;
            end else if (w_match) begin
               w_next = DATA;
            end else begin
               w_next = HUNT;
            end
         end
         DATA: begin
            if (w_timeout) begin
               w_next = HUNT;
            end else if (w_accept && w_last) begin
               w_next = DONE;
            end else begin
               w_next = DATA;
            end
         end
         DONE:    w_next = HUNT;
         default: w_next = HUNT;
      endcase
   end

   // Bit timing counter, first-edge flag, sync shifter and latched mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tcnt  <= {TCW{1'b0}};
         r_first <= 1'b1;
         r_shift <= {SYNC_LEN{1'b0}};
         r_mode  <= MODE_IEEE;
      end else begin
         if (w_accept) begin
            r_tcnt <= {TCW{1'b0}};
         end else if (r_tcnt != SAT_C) begin
            r_tcnt <= r_tcnt + TONE_C;
         end

         if (w_timeout) begin
            r_first <= 1'b1;
         end else if (w_accept) begin
            r_first <= 1'b0;
         end

         if (w_timeout || (r_state == DONE)) begin
            r_shift <= {SYNC_LEN{1'b0}};
         end else if ((r_state == HUNT) && w_accept) begin
            r_shift <= SYNC_LEN'({r_shift, w_bit});
         end

         if (r_state == HUNT) begin
            r_mode <= mode;
         end
      end
   end

   // Frame assembly: each data bit lands at its own index, LSB first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_asm    <= {FRAME_W{1'b0}};
         r_bitcnt <= {BCW{1'b0}};
      end else if (r_state == DATA) begin
         if (w_timeout) begin
            r_asm    <= {FRAME_W{1'b0}};
            r_bitcnt <= {BCW{1'b0}};
         end else if (w_accept) begin
            r_asm    <= w_bit ? (r_asm | w_mask) : (r_asm & ~w_mask);
            r_bitcnt <= r_bitcnt + BONE_C;
         end
      end else begin
         // DONE still shows the full count for its single cycle.
         r_bitcnt <= {BCW{1'b0}};
      end
   end

   // Output handshake, error and overrun pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data    <= {FRAME_W{1'b0}};
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_err     <= (r_state == DATA) && w_timeout;
         r_overrun <= 1'b0;
         if (r_state == DONE) begin
            // A frame being accepted this cycle frees the slot for the new one.
            if (!r_valid || i_ready) begin
               r_data  <= r_asm;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_err     = r_err;
   assign o_overrun = r_overrun;
   assign o_state   = r_state;
   assign o_bitcnt  = r_bitcnt;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_frame_decoder
// Directed bench for manchester_frame_decoder at SPB=8, FRAME_W=8, sync 1011.
// Line stimulus changes on falling clock edges; outputs are sampled on falling
// edges. Manchester levels are built by the bench from the bit values.
// -----------------------------------------------------------------------------
module tb_manchester_frame_decoder;

   localparam int SPB     = 8;
   localparam int FRAME_W = 8;

   logic       clk;
   logic       rst;
   logic       ser_in;
   logic       mode;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_err;
   logic       o_overrun;
   logic [1:0] o_state;
   logic [3:0] o_bitcnt;

   int n_checks = 0;
   int n_fail   = 0;

   int         mon_valid = 0;
   int         mon_err   = 0;
   int         mon_ovr   = 0;
   logic [7:0] mon_data  = 8'h00;

   manchester_frame_decoder #(
      .SPB          (SPB),
      .FRAME_W      (FRAME_W),
      .SYNC_LEN     (4),
      .SYNC_PATTERN (4'b1011)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data      (ser_in),
      .mode      (mode),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_err     (o_err),
      .o_overrun (o_overrun),
      .o_state   (o_state),
      .o_bitcnt  (o_bitcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running tallies of output activity, sampled away from the active edge.
   always @(negedge clk) begin
      if (o_valid) begin
         mon_valid <= mon_valid + 1;
         mon_data  <= o_data;
      end
      if (o_err)     mon_err <= mon_err + 1;
      if (o_overrun) mon_ovr <= mon_ovr + 1;
   end

   task automatic drive(input logic lvl, input int n);
      ser_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   // IEEE polarity: a 1 is low-then-high; inv flips the whole line.
   task automatic send_bit(input logic b, input logic inv);
      drive(~b ^ inv, SPB/2);
      drive(b ^ inv, SPB/2);
   endtask

   task automatic send_sync(input logic inv);
      send_bit(1'b1, inv);
      send_bit(1'b0, inv);
      send_bit(1'b1, inv);
      send_bit(1'b1, inv);
   endtask

   task automatic send_frame(input logic [7:0] val, input logic inv);
      drive(inv, 24);
      send_sync(inv);
      for (int i = 0; i < 8; i++) send_bit(val[i], inv);
      repeat (24) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (o_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data got=%h exp=00", o_data); end
      n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      n_checks++; if (o_err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", o_err); end
      n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", o_overrun); end
      n_checks++; if (o_state !== 2'b00)  begin n_fail++; $display("FAIL reset_state got=%b exp=00", o_state); end
      n_checks++; if (o_bitcnt !== 4'd0)  begin n_fail++; $display("FAIL reset_bitcnt got=%0d exp=0", o_bitcnt); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_ieee;
      int v0, e0;
      v0 = mon_valid; e0 = mon_err;
      send_frame(8'hA5, 1'b0);
      n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL ieee_valid_cycles got=%0d exp=1", mon_valid - v0); end
      n_checks++; if (mon_data !== 8'hA5)  begin n_fail++; $display("FAIL ieee_data got=%h exp=a5", mon_data); end
      n_checks++; if (mon_err - e0 != 0)   begin n_fail++; $display("FAIL ieee_err got=%0d exp=0", mon_err - e0); end
      n_checks++; if (o_bitcnt !== 4'd0)   begin n_fail++; $display("FAIL ieee_bitcnt got=%0d exp=0", o_bitcnt); end
      n_checks++; if (o_state !== 2'b00)   begin n_fail++; $display("FAIL ieee_state got=%b exp=00", o_state); end
   endtask

   task automatic test_thomas;
      int v0;
      mode = 1'b1;
      v0 = mon_valid;
      send_frame(8'hA5, 1'b1);
      n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL thomas_valid_cycles got=%0d exp=1", mon_valid - v0); end
      n_checks++; if (mon_data !== 8'hA5)  begin n_fail++; $display("FAIL thomas_data got=%h exp=a5", mon_data); end
      v0 = mon_valid;
      send_frame(8'hA5, 1'b0);
      n_checks++; if (mon_valid - v0 != 0) begin n_fail++; $display("FAIL thomas_wrong_polarity got=%0d exp=0", mon_valid - v0); end
      mode = 1'b0;
   endtask

   task automatic test_timeout;
      int pulses, pk, v0, e0;
      pulses = 0; pk = -1;
      drive(1'b0, 24);
      send_sync(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      drive(1'b0, SPB/2);
      ser_in = 1'b1;   // mid-bit edge of data bit 3, then the line stays put
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 5) begin
            n_checks++; if (o_bitcnt !== 4'd4) begin n_fail++; $display("FAIL tmo_bitcnt got=%0d exp=4", o_bitcnt); end
         end
         if (o_err) begin
            pulses++;
            pk = k;
         end
      end
      n_checks++; if (pulses != 1)       begin n_fail++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
      n_checks++; if (pk != 14)          begin n_fail++; $display("FAIL tmo_cycle got=%0d exp=14", pk); end
      n_checks++; if (o_state !== 2'b00) begin n_fail++; $display("FAIL tmo_state got=%b exp=00", o_state); end
      v0 = mon_valid; e0 = mon_err;
      send_frame(8'h3C, 1'b0);
      n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL tmo_next_valid got=%0d exp=1", mon_valid - v0); end
      n_checks++; if (mon_data !== 8'h3C)  begin n_fail++; $display("FAIL tmo_next_data got=%h exp=3c", mon_data); end
      n_checks++; if (mon_err - e0 != 0)   begin n_fail++; $display("FAIL tmo_next_err got=%0d exp=0", mon_err - e0); end
   endtask

   task automatic test_back_to_back;
      int o0;
      i_ready = 1'b0;
      o0 = mon_ovr;
      send_frame(8'h11, 1'b0);
      n_checks++; if (o_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_first_valid got=%b exp=1", o_valid); end
      n_checks++; if (o_data !== 8'h11)   begin n_fail++; $display("FAIL b2b_first_data got=%h exp=11", o_data); end
      send_frame(8'h22, 1'b0);
      n_checks++; if (mon_ovr - o0 != 1)  begin n_fail++; $display("FAIL b2b_overrun got=%0d exp=1", mon_ovr - o0); end
      n_checks++; if (o_data !== 8'h11)   begin n_fail++; $display("FAIL b2b_held_data got=%h exp=11", o_data); end
      n_checks++; if (o_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_held_valid got=%b exp=1", o_valid); end
      i_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL b2b_release got=%b exp=0", o_valid); end
   endtask

   // Data 0xAA after sync: line simply toggles at every mid-bit, so the
   // toggle spacing d sets the counter value (d-1) seen by each edge.
   task automatic test_jitter;
      int sp [8] = '{7, 11, 8, 8, 7, 11, 8, 8};
      int v0, e0;
      logic lvl;
      v0 = mon_valid; e0 = mon_err;
      drive(1'b0, 24);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      drive(1'b0, SPB/2);
      lvl = 1'b1;
      ser_in = lvl;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            // one-clock glitch seen at counter values 4 and 5
            repeat (5) @(negedge clk);
            ser_in = ~lvl;
            @(negedge clk);
            ser_in = lvl;
            repeat (2) @(negedge clk);
         end else begin
            repeat (sp[i]) @(negedge clk);
         end
         lvl = ~lvl;
         ser_in = lvl;
      end
      repeat (24) @(negedge clk);
      n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL jit_valid got=%0d exp=1", mon_valid - v0); end
      n_checks++; if (mon_data !== 8'hAA)  begin n_fail++; $display("FAIL jit_data got=%h exp=aa", mon_data); end
      n_checks++; if (mon_err - e0 != 0)   begin n_fail++; $display("FAIL jit_err got=%0d exp=0", mon_err - e0); end
   endtask

   task automatic test_reset_midframe;
      int v0, e0;
      drive(1'b0, 24);
      send_sync(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      drive(1'b0, 2);
      n_checks++; if (o_bitcnt !== 4'd4) begin n_fail++; $display("FAIL rstmid_pre_bitcnt got=%0d exp=4", o_bitcnt); end
      rst = 1'b0;
      #1;
      n_checks++; if (o_data !== 8'h00)   begin n_fail++; $display("FAIL rstmid_data got=%h exp=00", o_data); end
      n_checks++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", o_valid); end
      n_checks++; if (o_state !== 2'b00)  begin n_fail++; $display("FAIL rstmid_state got=%b exp=00", o_state); end
      n_checks++; if (o_bitcnt !== 4'd0)  begin n_fail++; $display("FAIL rstmid_bitcnt got=%0d exp=0", o_bitcnt); end
      n_checks++; if (o_err !== 1'b0)     begin n_fail++; $display("FAIL rstmid_err got=%b exp=0", o_err); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      v0 = mon_valid; e0 = mon_err;
      send_frame(8'hFF, 1'b0);
      n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL rstmid_next_valid got=%0d exp=1", mon_valid - v0); end
      n_checks++; if (mon_data !== 8'hFF)  begin n_fail++; $display("FAIL rstmid_next_data got=%h exp=ff", mon_data); end
      n_checks++; if (mon_err - e0 != 0)   begin n_fail++; $display("FAIL rstmid_next_err got=%0d exp=0", mon_err - e0); end
   endtask

   initial begin
      rst     = 1'b0;
      ser_in  = 1'b0;
      mode    = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      test_reset;
      test_basic_ieee;
      test_thomas;
      test_timeout;
      test_back_to_back;
      test_jitter;
      test_reset_midframe;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
